// File: rtl/mosaic_pkg.sv
// mosaic_pkg: shared pixel/SAD types, search states and size helpers for the mosaic block-matching stage
package mosaic_pkg;
  typedef enum logic [1:0] {LOAD_ROI, LOAD_POI, SEARCH, DONE} search_state_t;
  function automatic int clog_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int poi_n(input int pd, input int pw);
    return pd * pw;
  endfunction
  function automatic int noff(input int rd, input int rw, input int pd, input int pw);
    return (rd - pd + 1) * (rw - pw + 1);
  endfunction
  function automatic int sad_w(input int pix_w, input int pd, input int pw);
    return pix_w + $clog2(pd * pw) + 1;
  endfunction
  localparam int DEF_PIX_W = 8;
  typedef logic [DEF_PIX_W-1:0] pixel_t;
  typedef logic [sad_w(DEF_PIX_W, 4, 4)-1:0] sad_t;
endpackage

// File: rtl/sad_accum.sv
// sad_accum: abs-diff accumulator with running best-offset tracker; SAD_EARLY_EXIT_EN exposes an early-exit flag
module sad_accum #(
  parameter int PIX_W = 8,
  parameter int SAD_W = 13,
  parameter int ROW_W = 2,
  parameter int COL_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             last,
  input  logic [PIX_W-1:0] roi_pix,
  input  logic [PIX_W-1:0] poi_pix,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
`ifdef SAD_EARLY_EXIT_EN
  output logic             early_exit,
`endif
  output logic [SAD_W-1:0] best_sad,
  output logic [ROW_W-1:0] best_row,
  output logic [COL_W-1:0] best_col
);
  logic [SAD_W-1:0] acc_q, acc_d, best_sad_q, best_sad_d, sum;
  logic [ROW_W-1:0] best_row_q, best_row_d;
  logic [COL_W-1:0] best_col_q, best_col_d;
  logic [PIX_W-1:0] diff;
  assign diff = roi_pix > poi_pix ? roi_pix - poi_pix : poi_pix - roi_pix;
  assign sum = acc_q + SAD_W'(diff);
`ifdef SAD_EARLY_EXIT_EN
  assign early_exit = en && acc_q >= best_sad_q;
`endif
  always_comb begin
    acc_d = acc_q;
    best_sad_d = best_sad_q;
    best_row_d = best_row_q;
    best_col_d = best_col_q;
    if (clear) begin
      acc_d = '0;
      best_sad_d = '1;
      best_row_d = '0;
      best_col_d = '0;
    end
`ifdef SAD_EARLY_EXIT_EN
    else if (early_exit) acc_d = '0;
`endif
    else if (en && last) begin
      acc_d = '0;
      if (sum < best_sad_q) begin
        best_sad_d = sum;
        best_row_d = row;
        best_col_d = col;
      end
    end else if (en) acc_d = sum;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      best_sad_q <= '1;
      best_row_q <= '0;
      best_col_q <= '0;
    end else begin
      acc_q <= acc_d;
      best_sad_q <= best_sad_d;
      best_row_q <= best_row_d;
      best_col_q <= best_col_d;
    end
  end
  assign best_sad = best_sad_q;
  assign best_row = best_row_q;
  assign best_col = best_col_q;
endmodule

// File: rtl/poi_sad_search.sv
// poi_sad_search: buffers an ROI and a POI, then finds the lowest-SAD POI placement (SAD_EARLY_EXIT_EN skips losing offsets)
module poi_sad_search import mosaic_pkg::*; #(
  parameter int ROI_DEPTH = 6,
  parameter int ROI_WIDTH = 6,
  parameter int POI_DEPTH = 4,
  parameter int POI_WIDTH = 4,
  parameter int PIX_W = 8,
  localparam int ROW_W = clog_w(ROI_DEPTH - POI_DEPTH + 1),
  localparam int COL_W = clog_w(ROI_WIDTH - POI_WIDTH + 1),
  localparam int SAD_W = sad_w(PIX_W, POI_DEPTH, POI_WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic [SAD_W-1:0] out_sad,
  output logic             busy
);
  localparam int ROI_N = ROI_DEPTH * ROI_WIDTH;
  localparam int POI_N = poi_n(POI_DEPTH, POI_WIDTH);
  localparam int LD_W = clog_w(ROI_N);
  localparam int PA_W = clog_w(POI_N);
  localparam int PR_W = clog_w(POI_DEPTH);
  localparam int PC_W = clog_w(POI_WIDTH);
  localparam logic [LD_W-1:0] ROI_LAST = LD_W'(ROI_N - 1);
  localparam logic [LD_W-1:0] POI_LAST = LD_W'(POI_N - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROI_DEPTH - POI_DEPTH);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(ROI_WIDTH - POI_WIDTH);
  localparam logic [PR_W-1:0] PR_MAX = PR_W'(POI_DEPTH - 1);
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(POI_WIDTH - 1);
  search_state_t state_q, state_d;
  logic [LD_W-1:0] ld_q, ld_d;
  logic [ROW_W-1:0] oy_q, oy_d;
  logic [COL_W-1:0] ox_q, ox_d;
  logic [PR_W-1:0] pr_q, pr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PIX_W-1:0] roi_q [ROI_N];
  logic [PIX_W-1:0] roi_d [ROI_N];
  logic [PIX_W-1:0] poi_q [POI_N];
  logic [PIX_W-1:0] poi_d [POI_N];
  logic [LD_W-1:0] roi_addr;
  logic [PA_W-1:0] poi_addr;
  logic beat, pix_last, off_last, skip, clear;
  logic [SAD_W-1:0] best_sad;
  logic [ROW_W-1:0] best_row;
  logic [COL_W-1:0] best_col;
  assign in_ready = state_q == LOAD_ROI || state_q == LOAD_POI;
  assign busy = state_q == SEARCH;
  assign out_valid = state_q == DONE;
  assign out_row = out_valid ? best_row : '0;
  assign out_col = out_valid ? best_col : '0;
  assign out_sad = out_valid ? best_sad : '0;
  assign beat = in_valid && in_ready;
  assign clear = out_valid && out_ready;
  assign pix_last = pr_q == PR_MAX && pc_q == PC_MAX;
  assign off_last = oy_q == ROW_MAX && ox_q == COL_MAX;
  assign roi_addr = LD_W'((int'(oy_q) + int'(pr_q)) * ROI_WIDTH + int'(ox_q) + int'(pc_q));
  assign poi_addr = PA_W'(int'(pr_q) * POI_WIDTH + int'(pc_q));
`ifdef SAD_EARLY_EXIT_EN
  logic early_exit;
  assign skip = early_exit;
`else
  assign skip = 1'b0;
`endif
  sad_accum #(.PIX_W(PIX_W), .SAD_W(SAD_W), .ROW_W(ROW_W), .COL_W(COL_W)) u_acc (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .en(busy),
    .last(pix_last),
    .roi_pix(roi_q[roi_addr]),
    .poi_pix(poi_q[poi_addr]),
    .row(oy_q),
    .col(ox_q),
`ifdef SAD_EARLY_EXIT_EN
    .early_exit(early_exit),
`endif
    .best_sad(best_sad),
    .best_row(best_row),
    .best_col(best_col)
  );
  always_comb begin
    state_d = state_q;
    ld_d = ld_q;
    oy_d = oy_q;
    ox_d = ox_q;
    pr_d = pr_q;
    pc_d = pc_q;
    roi_d = roi_q;
    poi_d = poi_q;
    case (state_q)
      LOAD_ROI: if (beat) begin
        roi_d[ld_q] = in_pix;
        ld_d = ld_q == ROI_LAST ? '0 : ld_q + 1'b1;
        if (ld_q == ROI_LAST) state_d = LOAD_POI;
      end
      LOAD_POI: if (beat) begin
        poi_d[PA_W'(ld_q)] = in_pix;
        ld_d = ld_q == POI_LAST ? '0 : ld_q + 1'b1;
        if (ld_q == POI_LAST) state_d = SEARCH;
      end
      SEARCH: if (pix_last || skip) begin
        pr_d = '0;
        pc_d = '0;
        ox_d = ox_q == COL_MAX ? '0 : ox_q + 1'b1;
        if (ox_q == COL_MAX) oy_d = oy_q == ROW_MAX ? '0 : oy_q + 1'b1;
        if (off_last) state_d = DONE;
      end else begin
        pc_d = pc_q == PC_MAX ? '0 : pc_q + 1'b1;
        if (pc_q == PC_MAX) pr_d = pr_q + 1'b1;
      end
      DONE: if (out_ready) state_d = LOAD_ROI;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD_ROI;
      ld_q <= '0;
      oy_q <= '0;
      ox_q <= '0;
      pr_q <= '0;
      pc_q <= '0;
    end else begin
      state_q <= state_d;
      ld_q <= ld_d;
      oy_q <= oy_d;
      ox_q <= ox_d;
      pr_q <= pr_d;
      pc_q <= pc_d;
    end
  end
  always_ff @(posedge clk) begin
    roi_q <= roi_d;
    poi_q <= poi_d;
  end
endmodule
